// File: rtl/adma_pkg.sv
// Shared types and helpers for the AXI DDR DMA frame-buffer scheduler.
package adma_pkg;

  localparam int CNT_W = 16;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_SETUP = 2'd1,
    R_REQ   = 2'd2,
    R_BUSY  = 2'd3
  } rd_state_t;

  function automatic logic [31:0] buf_base(input logic [IDX_W-1:0] idx,
                                           input logic [31:0] base,
                                           input logic [31:0] size);
    return base + 32'(idx) * size;
  endfunction

  function automatic logic [31:0] buf_end(input logic [IDX_W-1:0] idx,
                                          input logic [31:0] base,
                                          input logic [31:0] size,
                                          input logic [31:0] frame_bytes);
    return buf_base(idx, base, size) + frame_bytes;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adma_rd_req_fsm.sv
// Read request sequencer: address setup, edge-style rd_req handshake with
// the DMA, busy tracking and request timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   R_IDLE  | no read in flight, waiting for a start from the scheduler
//   R_SETUP | read addresses just loaded, holding rd_req low one cycle
//   R_REQ   | rd_req high, waiting for the DMA to raise rd_req_busy
//   R_BUSY  | DMA reading the locked buffer, waiting for busy to drop
module adma_rd_req_fsm
  import adma_pkg::*;
#(
  parameter int REQ_TIMEOUT = 255
) (
  input  logic axi_clk,
  input  logic reset_n,
  input  logic clr,
  input  logic rd_start,
  input  logic rd_req_busy,
  output logic rd_idle,
  output logic rd_req,
  output logic rd_active,
  output logic err_timeout
);

  localparam int TMR_W = $clog2(REQ_TIMEOUT + 1);

  rd_state_t         state;
  logic [TMR_W-1:0]  tmr;

  assign rd_idle = (state == R_IDLE);

  // Read sequencing with a down-counting request timer (terminal count = 0).
  always_ff @(posedge axi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= R_IDLE;
      tmr         <= '0;
      rd_req      <= 1'b0;
      rd_active   <= 1'b0;
      err_timeout <= 1'b0;
    end else if (clr) begin
      state       <= R_IDLE;
      tmr         <= '0;
      rd_req      <= 1'b0;
      rd_active   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        R_IDLE: begin
          if (rd_start) begin
            state     <= R_SETUP;
            rd_active <= 1'b1;
          end
        end
        R_SETUP: begin
          state  <= R_REQ;
          rd_req <= 1'b1;
          tmr    <= TMR_W'(REQ_TIMEOUT - 1);
        end
        R_REQ: begin
          if (rd_req_busy) begin
            rd_req <= 1'b0;
            state  <= R_BUSY;
          end else if (tmr == '0) begin
            rd_req      <= 1'b0;
            err_timeout <= 1'b1;
            rd_active   <= 1'b0;
            state       <= R_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        R_BUSY: begin
          if (!rd_req_busy) begin
            state     <= R_IDLE;
            rd_active <= 1'b0;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adma_frame_sched.sv
// Frame-buffer scheduler: rotates write buffers around the read lock, picks
// the newest completed frame for reads and tracks drop/repeat statistics.
module adma_frame_sched
  import adma_pkg::*;
#(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          BUF_NUM        = 3,
  parameter logic [31:0] BUF_BASE       = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE       = 32'h0020_0000,
  parameter logic [31:0] FRAME_BYTES    = 32'h001F_A400,
  parameter int          REQ_TIMEOUT    = 255
) (
  input  logic                      axi_clk,
  input  logic                      reset_n,
  input  logic                      ddr_init_done,
  input  logic                      wr_frame_done,
  input  logic                      rd_frame_req,
  input  logic                      rd_req_busy,
  output logic [AXI_ADDR_WIDTH-1:0] wr_base_addr,
  output logic [AXI_ADDR_WIDTH-1:0] wr_end_addr,
  output logic [AXI_ADDR_WIDTH-1:0] rd_base_addr,
  output logic [AXI_ADDR_WIDTH-1:0] rd_end_addr,
  output logic                      rd_req,
  output logic                      rd_active,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [CNT_W-1:0]          repeat_cnt,
  output logic                      err_timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_NUM - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] RST_BASE = AXI_ADDR_WIDTH'(BUF_BASE);
  localparam logic [AXI_ADDR_WIDTH-1:0] RST_END  = AXI_ADDR_WIDTH'(BUF_BASE + FRAME_BYTES);

  logic [IDX_W-1:0] wr_idx, rd_idx, last_idx;
  logic             have_frame, new_flag;
  logic             rd_idle, rd_start;
  logic             lock_vld, wr_adv;
  logic [IDX_W-1:0] lock_idx, nxt_raw, nxt_idx;

  assign rd_start = rd_idle & rd_frame_req & have_frame & ddr_init_done;

  // Next write buffer: step once, and once more if that lands on the buffer
  // being read (or about to be read this very cycle).
  always_comb begin
    lock_vld = rd_start | rd_active;
    lock_idx = rd_start ? last_idx : rd_idx;
    nxt_raw  = (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
    nxt_idx  = nxt_raw;
    if (lock_vld && (nxt_raw == lock_idx))
      nxt_idx = (nxt_raw == LAST_IDX) ? '0 : nxt_raw + 1'b1;
    wr_adv = (nxt_idx != wr_idx);
  end

  // Buffer indices, registered addresses, frame bookkeeping and statistics.
  always_ff @(posedge axi_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      last_idx     <= '0;
      have_frame   <= 1'b0;
      new_flag     <= 1'b0;
      drop_cnt     <= '0;
      repeat_cnt   <= '0;
      wr_base_addr <= RST_BASE;
      wr_end_addr  <= RST_END;
      rd_base_addr <= RST_BASE;
      rd_end_addr  <= RST_END;
    end else if (!ddr_init_done) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      last_idx     <= '0;
      have_frame   <= 1'b0;
      new_flag     <= 1'b0;
      drop_cnt     <= '0;
      repeat_cnt   <= '0;
      wr_base_addr <= RST_BASE;
      wr_end_addr  <= RST_END;
      rd_base_addr <= RST_BASE;
      rd_end_addr  <= RST_END;
    end else begin
      if (rd_start) begin
        rd_idx       <= last_idx;
        rd_base_addr <= AXI_ADDR_WIDTH'(buf_base(last_idx, BUF_BASE, BUF_SIZE));
        rd_end_addr  <= AXI_ADDR_WIDTH'(buf_end(last_idx, BUF_BASE, BUF_SIZE, FRAME_BYTES));
        if (!new_flag)
          repeat_cnt <= sat_inc(repeat_cnt);
      end
      if (wr_frame_done) begin
        if (wr_adv) begin
          last_idx     <= wr_idx;
          wr_idx       <= nxt_idx;
          have_frame   <= 1'b1;
          wr_base_addr <= AXI_ADDR_WIDTH'(buf_base(nxt_idx, BUF_BASE, BUF_SIZE));
          wr_end_addr  <= AXI_ADDR_WIDTH'(buf_end(nxt_idx, BUF_BASE, BUF_SIZE, FRAME_BYTES));
          // A frame being picked up by a read this cycle is not a drop.
          if (new_flag && !rd_start)
            drop_cnt <= sat_inc(drop_cnt);
        end else begin
          drop_cnt <= sat_inc(drop_cnt);
        end
      end
      if (wr_frame_done && wr_adv)
        new_flag <= 1'b1;
      else if (rd_start)
        new_flag <= 1'b0;
    end
  end

  adma_rd_req_fsm #(
    .REQ_TIMEOUT (REQ_TIMEOUT)
  ) u_rd_fsm (
    .axi_clk     (axi_clk),
    .reset_n     (reset_n),
    .clr         (~ddr_init_done),
    .rd_start    (rd_start),
    .rd_req_busy (rd_req_busy),
    .rd_idle     (rd_idle),
    .rd_req      (rd_req),
    .rd_active   (rd_active),
    .err_timeout (err_timeout)
  );

endmodule

// File: tb/tb_adma_frame_sched.sv
// Directed bench for adma_frame_sched: a 3-buffer instance plus a 2-buffer
// instance sharing the same stimulus.
module tb_adma_frame_sched;

  logic axi_clk       = 1'b0;
  logic reset_n       = 1'b0;
  logic ddr_init_done = 1'b0;
  logic wr_frame_done = 1'b0;
  logic rd_frame_req  = 1'b0;
  logic rd_req_busy   = 1'b0;

  logic [31:0] wr_base_addr, wr_end_addr, rd_base_addr, rd_end_addr;
  logic        rd_req, rd_active, err_timeout;
  logic [15:0] drop_cnt, repeat_cnt;

  logic [31:0] wr_base_2, wr_end_2, rd_base_2, rd_end_2;
  logic        rd_req_2, rd_active_2, err_timeout_2;
  logic [15:0] drop_cnt_2, repeat_cnt_2;

  int n_chk  = 0;
  int n_fail = 0;
  int hi_cnt;

  always #5 axi_clk = ~axi_clk;

  adma_frame_sched u_dut (
    .axi_clk       (axi_clk),
    .reset_n       (reset_n),
    .ddr_init_done (ddr_init_done),
    .wr_frame_done (wr_frame_done),
    .rd_frame_req  (rd_frame_req),
    .rd_req_busy   (rd_req_busy),
    .wr_base_addr  (wr_base_addr),
    .wr_end_addr   (wr_end_addr),
    .rd_base_addr  (rd_base_addr),
    .rd_end_addr   (rd_end_addr),
    .rd_req        (rd_req),
    .rd_active     (rd_active),
    .drop_cnt      (drop_cnt),
    .repeat_cnt    (repeat_cnt),
    .err_timeout   (err_timeout)
  );

  adma_frame_sched #(.BUF_NUM(2)) u_dut2 (
    .axi_clk       (axi_clk),
    .reset_n       (reset_n),
    .ddr_init_done (ddr_init_done),
    .wr_frame_done (wr_frame_done),
    .rd_frame_req  (rd_frame_req),
    .rd_req_busy   (rd_req_busy),
    .wr_base_addr  (wr_base_2),
    .wr_end_addr   (wr_end_2),
    .rd_base_addr  (rd_base_2),
    .rd_end_addr   (rd_end_2),
    .rd_req        (rd_req_2),
    .rd_active     (rd_active_2),
    .drop_cnt      (drop_cnt_2),
    .repeat_cnt    (repeat_cnt_2),
    .err_timeout   (err_timeout_2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic pulse_wr();
    wr_frame_done = 1'b1;
    cyc();
    wr_frame_done = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_frame_req = 1'b1;
    cyc();
    rd_frame_req = 1'b0;
  endtask

  // From R_SETUP: request, busy handshake, release.
  task automatic finish_rd();
    cyc();
    rd_req_busy = 1'b1;
    cyc();
    rd_req_busy = 1'b0;
    cyc();
  endtask

  initial begin
    repeat (3) cyc();
    check_val("rst_wr_base", wr_base_addr, 32'h0000_0000);
    check_val("rst_wr_end", wr_end_addr, 32'h001F_A400);
    check_val("rst_rd_base", rd_base_addr, 32'h0000_0000);
    check_val("rst_rd_end", rd_end_addr, 32'h001F_A400);
    check_val("rst_rd_req", rd_req, 0);
    check_val("rst_rd_active", rd_active, 0);
    check_val("rst_drop", drop_cnt, 0);
    check_val("rst_repeat", repeat_cnt, 0);
    check_val("rst_err", err_timeout, 0);
    reset_n = 1'b1;
    cyc();

    // ddr_init_done low: pulses ignored
    wr_frame_done = 1'b1;
    rd_frame_req  = 1'b1;
    cyc();
    wr_frame_done = 1'b0;
    rd_frame_req  = 1'b0;
    cyc();
    check_val("noddr_wr_base", wr_base_addr, 32'h0000_0000);
    check_val("noddr_wr_end", wr_end_addr, 32'h001F_A400);
    check_val("noddr_rd_req", rd_req, 0);
    check_val("noddr_rd_active", rd_active, 0);
    check_val("noddr_drop", drop_cnt, 0);

    // no completed frame yet: read request ignored
    ddr_init_done = 1'b1;
    cyc();
    pulse_rd();
    check_val("noframe_active", rd_active, 0);
    cyc();
    check_val("noframe_rd_req", rd_req, 0);
    check_val("noframe_repeat", repeat_cnt, 0);

    // BUF_NUM=2: write cannot advance past the locked buffer
    pulse_wr();
    pulse_rd();
    finish_rd();
    pulse_wr();
    check_val("b2_wr_base0", wr_base_2, 32'h0000_0000);
    check_val("b2_drop0", drop_cnt_2, 0);
    pulse_rd();
    check_val("b2_rd_base", rd_base_2, 32'h0020_0000);
    cyc();
    rd_req_busy = 1'b1;
    cyc();
    pulse_wr();
    check_val("b2_wr_base_hold", wr_base_2, 32'h0000_0000);
    check_val("b2_drop1", drop_cnt_2, 1);
    check_val("b2_active", rd_active_2, 1);
    rd_req_busy = 1'b0;
    cyc();
    check_val("b2_released", rd_active_2, 0);

    // mid-operation ddr_init_done drop clears state
    ddr_init_done = 1'b0;
    cyc();
    ddr_init_done = 1'b1;
    cyc();
    check_val("clr_wr_base", wr_base_addr, 32'h0000_0000);
    check_val("clr_drop_b2", drop_cnt_2, 0);

    // rotation without reads
    pulse_wr();
    check_val("rot1_base", wr_base_addr, 32'h0020_0000);
    check_val("rot1_end", wr_end_addr, 32'h003F_A400);
    pulse_wr();
    check_val("rot2_base", wr_base_addr, 32'h0040_0000);
    pulse_wr();
    check_val("rot3_base", wr_base_addr, 32'h0000_0000);
    pulse_wr();
    check_val("rot4_base", wr_base_addr, 32'h0020_0000);
    check_val("rot_drop", drop_cnt, 3);
    ddr_init_done = 1'b0;
    cyc();
    ddr_init_done = 1'b1;
    cyc();

    // read handshake on frame 0
    pulse_wr();
    pulse_rd();
    check_val("hs_rd_base", rd_base_addr, 32'h0000_0000);
    check_val("hs_rd_end", rd_end_addr, 32'h001F_A400);
    check_val("hs_active", rd_active, 1);
    check_val("hs_setup_req", rd_req, 0);
    cyc();
    check_val("hs_req_rise", rd_req, 1);
    cyc();
    check_val("hs_req_hold", rd_req, 1);
    rd_req_busy = 1'b1;
    cyc();
    check_val("hs_req_fall", rd_req, 0);
    check_val("hs_repeat", repeat_cnt, 0);

    // lock skip while buffer 0 is being read
    pulse_wr();
    check_val("lk_wr_base2", wr_base_addr, 32'h0040_0000);
    pulse_wr();
    check_val("lk_wr_skip", wr_base_addr, 32'h0020_0000);
    check_val("lk_drop", drop_cnt, 1);
    check_val("lk_active", rd_active, 1);
    rd_req_busy = 1'b0;
    cyc();
    check_val("hs_released", rd_active, 0);

    // same-cycle read start and write done (last_idx = 2, wr_idx = 1)
    wr_frame_done = 1'b1;
    rd_frame_req  = 1'b1;
    cyc();
    wr_frame_done = 1'b0;
    rd_frame_req  = 1'b0;
    check_val("sc_wr_base", wr_base_addr, 32'h0000_0000);
    check_val("sc_rd_base", rd_base_addr, 32'h0040_0000);
    check_val("sc_rd_end", rd_end_addr, 32'h005F_A400);
    check_val("sc_drop", drop_cnt, 1);
    check_val("sc_repeat", repeat_cnt, 0);
    finish_rd();
    check_val("sc_released", rd_active, 0);

    // repeat reads of frame 1
    pulse_rd();
    check_val("rp1_rd_base", rd_base_addr, 32'h0020_0000);
    finish_rd();
    check_val("rp1_repeat", repeat_cnt, 0);
    pulse_rd();
    check_val("rp2_rd_base", rd_base_addr, 32'h0020_0000);
    cyc();
    rd_req_busy = 1'b1;
    cyc();
    pulse_rd();
    rd_req_busy = 1'b0;
    cyc();
    check_val("rp2_repeat", repeat_cnt, 1);
    check_val("rp2_released", rd_active, 0);

    // request timeout
    pulse_rd();
    hi_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (rd_req) hi_cnt++;
      else if (hi_cnt != 0) break;
    end
    check_val("to_req_cycles", hi_cnt, 255);
    check_val("to_err", err_timeout, 1);
    check_val("to_active", rd_active, 0);
    check_val("to_repeat", repeat_cnt, 2);

    // async reset while in R_BUSY
    pulse_rd();
    cyc();
    rd_req_busy = 1'b1;
    cyc();
    check_val("mr_active", rd_active, 1);
    check_val("mr_err_sticky", err_timeout, 1);
    reset_n = 1'b0;
    #1;
    check_val("mr_rd_active", rd_active, 0);
    check_val("mr_rd_req", rd_req, 0);
    check_val("mr_err", err_timeout, 0);
    check_val("mr_drop", drop_cnt, 0);
    check_val("mr_repeat", repeat_cnt, 0);
    check_val("mr_wr_base", wr_base_addr, 32'h0000_0000);
    check_val("mr_wr_end", wr_end_addr, 32'h001F_A400);
    check_val("mr_rd_base", rd_base_addr, 32'h0000_0000);
    rd_req_busy = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
